// File: rtl/dem_bcd_tham_so.sv
// rtl/dem_bcd_tham_so.sv - parameterised two-digit BCD up/down counter with preset, wrap pulse and divided clock
module dem_bcd_tham_so #(
    parameter int MODULO = 60,
    parameter int HALF   = MODULO / 2
) (
    input  logic       clk,
    input  logic       rs,
    input  logic       en,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] load_donvi,
    input  logic [3:0] load_chuc,
    output logic [3:0] led1,
    output logic [3:0] led2,
    output logic       carry,
    output logic       clk_out,
    output logic       load_err
);

    // Terminal count and half-point split into digits so every compare stays in BCD
    localparam logic [3:0] MAX_CHUC   = 4'((MODULO - 1) / 10);
    localparam logic [3:0] MAX_DONVI  = 4'((MODULO - 1) % 10);
    localparam logic [7:0] HALF_CHUC  = 8'(HALF / 10);
    localparam logic [3:0] HALF_DONVI = 4'(HALF % 10);

    logic [3:0] r_donvi;
    logic [3:0] r_chuc;
    logic       r_carry;
    logic       r_clk_out;
    logic       r_load_err;

    logic [3:0] w_donvi_nxt;
    logic [3:0] w_chuc_nxt;
    logic       w_carry_nxt;
    logic       w_load_err_nxt;
    logic       w_load_ok;
    logic       w_at_max;
    logic       w_at_zero;
    logic       w_below_half;

    assign w_at_max  = (r_chuc == MAX_CHUC) && (r_donvi == MAX_DONVI);
    assign w_at_zero = (r_chuc == 4'd0) && (r_donvi == 4'd0);

    always_comb begin
        w_load_ok = (load_donvi <= 4'd9) && (load_chuc <= 4'd9) &&
                    ((load_chuc < MAX_CHUC) ||
                     ((load_chuc == MAX_CHUC) && (load_donvi <= MAX_DONVI)));
        w_donvi_nxt    = r_donvi;
        w_chuc_nxt     = r_chuc;
        w_carry_nxt    = 1'b0;
        w_load_err_nxt = 1'b0;
        if (load) begin
            if (w_load_ok) begin
                w_donvi_nxt = load_donvi;
                w_chuc_nxt  = load_chuc;
            end else begin
                w_load_err_nxt = 1'b1;
            end
        end else if (en) begin
            if (!dir) begin
                if (w_at_max) begin
                    w_donvi_nxt = 4'd0;
                    w_chuc_nxt  = 4'd0;
                    w_carry_nxt = 1'b1;
                end else if (r_donvi == 4'd9) begin
                    w_donvi_nxt = 4'd0;
                    w_chuc_nxt  = r_chuc + 4'd1;
                end else begin
                    w_donvi_nxt = r_donvi + 4'd1;
                end
            end else begin
                if (w_at_zero) begin
                    w_donvi_nxt = MAX_DONVI;
                    w_chuc_nxt  = MAX_CHUC;
                    w_carry_nxt = 1'b1;
                end else if (r_donvi == 4'd0) begin
                    w_donvi_nxt = 4'd9;
                    w_chuc_nxt  = r_chuc - 4'd1;
                end else begin
                    w_donvi_nxt = r_donvi - 4'd1;
                end
            end
        end
        // clk_out is decided from the next value so it changes together with the digits
        w_below_half = ({4'd0, w_chuc_nxt} < HALF_CHUC) ||
                       (({4'd0, w_chuc_nxt} == HALF_CHUC) && (w_donvi_nxt < HALF_DONVI));
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            r_donvi    <= 4'd0;
            r_chuc     <= 4'd0;
            r_carry    <= 1'b0;
            r_load_err <= 1'b0;
            r_clk_out  <= 1'b1;
        end else begin
            r_donvi    <= w_donvi_nxt;
            r_chuc     <= w_chuc_nxt;
            r_carry    <= w_carry_nxt;
            r_load_err <= w_load_err_nxt;
            r_clk_out  <= w_below_half;
        end
    end

    assign led1     = r_donvi;
    assign led2     = r_chuc;
    assign carry    = r_carry;
    assign clk_out  = r_clk_out;
    assign load_err = r_load_err;

endmodule

// File: doc/dem_bcd_tham_so.md
DEM_BCD_THAM_SO -- requirements
Module: dem_bcd_tham_so

Interface
REQ-001 Parameter MODULO, default 60: count modulus; legal range 2..99; count runs 0..MODULO-1.
REQ-002 Parameter HALF, default MODULO/2 (integer division): count value at which clk_out drops low.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rs  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  count enable; one count step per clk edge while high.
REQ-006 dir  input  1  direction; 0 = up, 1 = down.
REQ-007 load  input  1  synchronous preset strobe.
REQ-008 load_donvi  input  4  BCD units digit to preset.
REQ-009 load_chuc  input  4  BCD tens digit to preset.
REQ-010 led1  output  4  BCD units digit of current count.
REQ-011 led2  output  4  BCD tens digit of current count.
REQ-012 carry  output  1  one-cycle wrap pulse (up overflow or down underflow).
REQ-013 clk_out  output  1  divided square wave, period MODULO counts.
REQ-014 load_err  output  1  one-cycle pulse flagging a rejected preset.

Function
REQ-015 Count state SHALL be held as two BCD digits (chuc, donvi), each always 0..9; value = 10*chuc + donvi.
REQ-016 Per-edge priority SHALL be rs > load > en; with none active, state holds and carry/load_err = 0.
REQ-017 Up step (en=1, dir=0): donvi 9 -> 0 with chuc+1; otherwise donvi+1.
REQ-018 Up wrap: at value MODULO-1, next value SHALL be 0 (both digits) and carry = 1 in the cycle showing 0.
REQ-019 Down step (en=1, dir=1): donvi 0 -> 9 with chuc-1; otherwise donvi-1.
REQ-020 Down wrap: at value 0, next value SHALL be MODULO-1 in BCD and carry = 1 in the cycle showing MODULO-1.
REQ-021 carry SHALL be registered, high exactly one cycle per wrap, never high when en=0.
REQ-022 Direction change SHALL take effect on the next enabled edge, with no skipped or repeated value.
REQ-023 Load accepted when load_donvi <= 9, load_chuc <= 9 and value < MODULO: count takes the preset next cycle; carry = 0.
REQ-024 Load rejected otherwise: count holds, load_err = 1 for one cycle; en ignored that cycle.
REQ-025 clk_out SHALL be registered and equal 1 when displayed value < HALF, else 0; it updates in the same cycle as led1/led2.
REQ-026 With MODULO=60, HALF=30, up-count: clk_out high for values 0..29, low for 30..59, rising in the cycle the count wraps to 0.
REQ-027 led1/led2 SHALL be direct register outputs, zero combinational logic after the flops.
REQ-028 Arithmetic SHALL stay within 4-bit digits; no binary-to-BCD conversion path.

Reset
REQ-029 rs=1 at a clk edge: led1 = 0, led2 = 0, carry = 0, load_err = 0, clk_out = 1 next cycle.
REQ-030 rs SHALL override load and en in the same cycle; mid-count reset restarts from 0 on the next enabled edge.
REQ-031 Power-up contents before the first rs are undefined; the bench SHALL assert rs for at least one edge.

Verification
REQ-032 Defaults, rs then en=1, dir=0 for 60 edges -> led2:led1 steps 00..59 then 00; carry one pulse at 00; clk_out 1->0 at 30, 0->1 at 00.
REQ-033 rs, en=1, dir=1 for 2 edges -> values 59, 58; carry pulse with 59; clk_out = 0.
REQ-034 load=1, chuc=5, donvi=8, then en up for 2 edges -> 58, 59, 00 with carry at 00; load with chuc=6, donvi=0 -> count holds, load_err one pulse.
REQ-035 load=1 with donvi=4'hA -> rejected, load_err = 1; load and en together -> preset wins, no step.
REQ-036 MODULO=24, HALF=12, up-count from 23 -> 00 with carry; down from 00 -> 23; clk_out low for 12..23.
REQ-037 rs asserted at count 37 with load=1 and en=1 -> next cycle 00, carry = 0, load_err = 0, clk_out = 1.
